// File: rtl/dm_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with a 4-state FSM and an interrupt request.
// Optional write log to the console when DM_TIMER_WRITE_LOG_EN is defined.
module dm_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic        WE,
    input  logic [3:0]  ByteEN,
    input  logic [31:0] DataW,
    input  logic [31:0] CurPC,
    output logic        Hit,
    output logic [31:0] DataR,
    output logic        IRQ,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      cur, nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        wr, wr_ctrl, wr_preset, wr_clear;
    logic [3:0]  ctrl_merged;
    logic [31:0] preset_merged;
    logic [31:0] count_nxt;
    logic        flag_set, flag_clr_fsm, en_clr;

    assign Hit       = (Adr[31:4] == BASE[31:4]) && (Adr[3:2] != 2'b11);
    assign wr        = Hit & WE;
    assign wr_ctrl   = wr && (Adr[3:2] == 2'b00);
    assign wr_preset = wr && (Adr[3:2] == 2'b01);
    assign wr_clear  = (wr_ctrl | wr_preset) & (|ByteEN);

    assign ctrl_merged = ByteEN[0] ? DataW[3:0] : ctrl;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            preset_merged[i*8 +: 8] = ByteEN[i] ? DataW[i*8 +: 8] : preset[i*8 +: 8];
        end
    end

    // Reads return pre-write contents of the current cycle.
    always_comb begin
        DataR = '0;
        if (Hit) begin
            case (Adr[3:2])
                2'b00:   DataR = {28'b0, ctrl};
                2'b01:   DataR = preset;
                2'b10:   DataR = count;
                default: DataR = '0;
            endcase
        end
    end

    assign IRQ   = irq_flag & ctrl[3];
    assign state = cur;

    // Next-state logic works on register values from before this cycle's write.
    always_comb begin
        nxt          = cur;
        count_nxt    = count;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (cur)
            S_IDLE: begin
                if (ctrl[0]) nxt = S_LOAD;
            end
            S_LOAD: begin
                count_nxt = preset;
                if (preset == 32'd0) begin
                    nxt      = S_INT;
                    flag_set = 1'b1;
                end else begin
                    nxt = S_CNT;
                end
            end
            S_CNT: begin
                if (!ctrl[0]) begin
                    nxt = S_IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    count_nxt = 32'd0;
                    nxt       = S_INT;
                    flag_set  = 1'b1;
                end
            end
            S_INT: begin
                if (ctrl[2:1] == 2'b00) begin
                    en_clr = 1'b1;
                    nxt    = S_IDLE;
                end else begin
                    flag_clr_fsm = 1'b1;
                    nxt          = S_LOAD;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            cur   <= nxt;
            count <= count_nxt;
            // A CPU write to the En byte overrides the one-shot En clear.
            if (wr_ctrl && ByteEN[0]) ctrl <= ctrl_merged;
            else if (en_clr)          ctrl[0] <= 1'b0;
            if (wr_preset) preset <= preset_merged;
            if (flag_set)                      irq_flag <= 1'b1;
            else if (wr_clear || flag_clr_fsm) irq_flag <= 1'b0;
        end
    end

`ifdef DM_TIMER_WRITE_LOG_EN
    logic [31:0] log_value;
    always_comb begin
        case (Adr[3:2])
            2'b00:   log_value = {28'b0, ctrl_merged};
            2'b01:   log_value = preset_merged;
            default: log_value = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            $display("%d@%h: *%h <= %h", $time, CurPC, {Adr[31:2], 2'b00}, log_value);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Adr[1:0], DataW[31:4]} ^ (|DataW[3:0]);
`else
    logic unused_bits;
    assign unused_bits = ^{CurPC, Adr[1:0]};
`endif

endmodule

// File: tb/tb_dm_timer.sv
// Directed bench for dm_timer: reset, one-shot, auto-reload, byte enables, pause,
// write/INT collision, set-vs-clear priority and reset with IRQ pending.
module tb_dm_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr;
    logic        WE;
    logic [3:0]  ByteEN;
    logic [31:0] DataW;
    logic [31:0] CurPC;
    logic        Hit;
    logic [31:0] DataR;
    logic        IRQ;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dm_timer #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .Adr    (Adr),
        .WE     (WE),
        .ByteEN (ByteEN),
        .DataW  (DataW),
        .CurPC  (CurPC),
        .Hit    (Hit),
        .DataR  (DataR),
        .IRQ    (IRQ),
        .state  (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
        Adr    = BASE + {28'b0, off};
        DataW  = d;
        ByteEN = be;
        WE     = 1'b1;
        CurPC  = CurPC + 32'd4;
        tick();
        WE     = 1'b0;
        ByteEN = 4'd0;
    endtask

    task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        Adr = BASE + {28'b0, off};
        #1;
        check(tag, DataR, exp);
    endtask

    initial begin
        reset  = 1'b1;
        Adr    = BASE;
        WE     = 1'b0;
        ByteEN = 4'd0;
        DataW  = 32'd0;
        CurPC  = 32'h0000_3000;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        rd("rst_ctrl", 4'h0, 32'd0);
        check("rst_hit", Hit, 1'b1);
        rd("rst_preset", 4'h4, 32'd0);
        rd("rst_count", 4'h8, 32'd0);
        check("rst_irq", IRQ, 1'b0);
        check("rst_state", state, 2'd0);

        // one-shot, PRESET=3
        wr(4'h4, 32'd3, 4'hF);
        wr(4'h0, 32'h9, 4'hF);
        check("os_e0_state", state, 2'd0);
        tick();
        check("os_e1_state", state, 2'd1);
        tick();
        rd("os_e2_count", 4'h8, 32'd3);
        check("os_e2_state", state, 2'd2);
        tick();
        rd("os_e3_count", 4'h8, 32'd2);
        tick();
        rd("os_e4_count", 4'h8, 32'd1);
        check("os_e4_irq", IRQ, 1'b0);
        tick();
        rd("os_e5_count", 4'h8, 32'd0);
        check("os_e5_irq", IRQ, 1'b1);
        check("os_e5_state", state, 2'd3);
        tick();
        check("os_e6_irq", IRQ, 1'b1);
        check("os_e6_state", state, 2'd0);
        rd("os_e6_ctrl", 4'h0, 32'h8);
        tick();
        check("os_e7_irq", IRQ, 1'b1);
        wr(4'h0, 32'h8, 4'hF);
        check("os_clr_irq", IRQ, 1'b0);

        // auto-reload, PRESET=2: pulse every 4 cycles
        wr(4'h4, 32'd2, 4'hF);
        wr(4'h0, 32'hB, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("ar2_irq_%0d", k), IRQ, (k % 4 == 0) ? 1'b1 : 1'b0);
        end
        wr(4'h0, 32'h0, 4'hF);
        tick();
        tick();
        check("ar2_stop_state", state, 2'd0);

        // auto-reload, PRESET=0: pulse every 2 cycles
        wr(4'h4, 32'd0, 4'hF);
        wr(4'h0, 32'hB, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ar0_irq_%0d", k), IRQ, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        wr(4'h0, 32'h0, 4'hF);
        tick();
        tick();
        check("ar0_stop_state", state, 2'd0);
        check("ar0_stop_irq", IRQ, 1'b0);

        // byte enables and decode
        wr(4'h4, 32'd0, 4'hF);
        wr(4'h4, 32'hAABB_CCDD, 4'b0101);
        rd("be_preset", 4'h4, 32'h00BB_00DD);
        wr(4'h4, 32'h1111_1111, 4'b0000);
        rd("be_none", 4'h4, 32'h00BB_00DD);
        rd("unmapped_data", 4'hC, 32'd0);
        check("unmapped_hit", Hit, 1'b0);
        Adr = BASE + 32'h10;
        #1;
        check("outside_hit", Hit, 1'b0);
        check("outside_data", DataR, 32'd0);

        // pause and resume, PRESET=10
        wr(4'h4, 32'd10, 4'hF);
        wr(4'h0, 32'h1, 4'hF);
        for (int k = 1; k <= 5; k++) tick();
        rd("pz_count7", 4'h8, 32'd7);
        wr(4'h0, 32'h0, 4'hF);
        rd("pz_count6", 4'h8, 32'd6);
        rd("pz_ctrl0", 4'h0, 32'd0);
        tick();
        check("pz_idle", state, 2'd0);
        rd("pz_hold", 4'h8, 32'd6);
        wr(4'h8, 32'h1234_5678, 4'hF);
        rd("count_ro", 4'h8, 32'd6);
        wr(4'h0, 32'h1, 4'hF);
        tick();
        check("pz_load", state, 2'd1);
        tick();
        rd("pz_reload", 4'h8, 32'd10);
        check("pz_cnt", state, 2'd2);
        wr(4'h0, 32'h0, 4'hF);
        tick();
        check("pz_stop", state, 2'd0);

        // CTRL write on the INT edge keeps En
        wr(4'h4, 32'd5, 4'hF);
        wr(4'h0, 32'h9, 4'hF);
        for (int k = 1; k <= 7; k++) tick();
        check("ie_irq", IRQ, 1'b1);
        check("ie_state_int", state, 2'd3);
        wr(4'h0, 32'h9, 4'hF);
        rd("ie_ctrl", 4'h0, 32'h9);
        check("ie_state_idle", state, 2'd0);
        check("ie_irq_clr", IRQ, 1'b0);
        tick();
        check("ie_load", state, 2'd1);
        tick();
        rd("ie_count5", 4'h8, 32'd5);

        // reset mid-count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmc_state", state, 2'd0);
        rd("rmc_count", 4'h8, 32'd0);
        rd("rmc_ctrl", 4'h0, 32'd0);
        rd("rmc_preset", 4'h4, 32'd0);

        // flag set beats a same-cycle PRESET write clear
        wr(4'h4, 32'd0, 4'hF);
        wr(4'h0, 32'h9, 4'hF);
        tick();
        wr(4'h4, 32'd5, 4'hF);
        check("sw_irq", IRQ, 1'b1);
        check("sw_state", state, 2'd3);
        rd("sw_preset", 4'h4, 32'd5);
        tick();
        check("sw_irq_hold", IRQ, 1'b1);
        check("sw_idle", state, 2'd0);
        rd("sw_ctrl", 4'h0, 32'h8);

        // reset with IRQ pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rirq_irq", IRQ, 1'b0);
        check("rirq_state", state, 2'd0);
        rd("rirq_preset", 4'h4, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
